// File: rtl/tjpu_pkg.sv
// Shared definitions for the concat FIFO read path: FSM encoding and skid buffer sizing.
package tjpu_pkg;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_READ     = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/concat_skid_buf.sv
// Two-entry in-order skid buffer; head is always entry 0, so downstream data is a register.
module concat_skid_buf
    import tjpu_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [OCC_W-1:0] cnt;

    // Shift-style storage: pops move entry1 forward, pushes land in the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == '0) begin
                        entry0 <= din;
                    end else begin
                        entry1 <= din;
                    end
                    cnt <= cnt + OCC_W'(1);
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - OCC_W'(1);
                end
                2'b11: begin
                    if (cnt == OCC_W'(SKID_DEPTH)) begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end else begin
                        entry0 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign occ  = cnt;
    assign head = entry0;

endmodule

// File: rtl/concat_burst_reader.sv
// Read-side master for the concat staging FIFO: requests bursts via M_count, pops them
// once M_Ready is trustworthy, and streams the words out through a credit-guarded skid buffer.
module concat_burst_reader
    import tjpu_pkg::*;
#(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned LEN_BITS   = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_BITS-1:0]   total_words,
    input  logic [ADDR_BITS:0]    burst_len,
    output logic [ADDR_BITS:0]    M_count,
    input  logic                  M_Ready,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [WIDTH-1:0]      fifo_dout,
    output logic                  m_valid,
    output logic [WIDTH-1:0]      m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = ADDR_BITS + 1;
    localparam int unsigned CMP_W = (LEN_BITS > CNT_W) ? LEN_BITS : CNT_W;

    state_t             state;
    state_t             next_state;
    logic [LEN_BITS-1:0] remaining;
    logic [CNT_W-1:0]    blen;
    logic [CNT_W-1:0]    burst_cnt;
    logic [CNT_W-1:0]    mcount_q;
    logic                wait_first;
    logic                inflight;
    logic                busy_q;
    logic                done_q;

    logic [OCC_W-1:0]    occ;
    logic [CNT_W-1:0]    blen_in_c;
    logic [CNT_W-1:0]    burst_size_c;
    logic [2:0]          credit_sum_c;
    logic                credit_ok_c;
    logic                pop_c;
    logic                rd_en_c;

    assign pop_c   = m_valid & m_ready;
    assign m_valid = (occ != '0);

    // Burst length as latched at start: zero means one word, never more than the FIFO holds.
    always_comb begin
        blen_in_c = burst_len;
        if (burst_len == '0) begin
            blen_in_c = CNT_W'(1);
        end else if (burst_len > CNT_W'(FIFO_DEPTH)) begin
            blen_in_c = CNT_W'(FIFO_DEPTH);
        end
    end

    // Next burst is the nominal length, shortened for the tail of the layer.
    always_comb begin
        burst_size_c = blen;
        if (CMP_W'(blen) > CMP_W'(remaining)) begin
            burst_size_c = CNT_W'(remaining);
        end
    end

    // A pop is allowed only if the skid buffer will still have room when its data lands.
    assign credit_sum_c = 3'(occ) + 3'(inflight) - 3'(pop_c);
    assign credit_ok_c  = (credit_sum_c < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rd_en_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (total_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                next_state = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                // M_Ready in the first cycle still reflects the previous M_count.
                if (!wait_first && M_Ready) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                rd_en_c = (burst_cnt != '0) & !fifo_empty & credit_ok_c;
                if (rd_en_c && (burst_cnt == CNT_W'(1))) begin
                    next_state = (remaining == LEN_BITS'(1)) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!inflight && ((occ == '0) || ((occ == OCC_W'(1)) && pop_c))) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Counters, burst request register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= '0;
            blen       <= '0;
            burst_cnt  <= '0;
            mcount_q   <= '0;
            wait_first <= 1'b0;
            inflight   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= total_words;
                        blen      <= blen_in_c;
                    end
                end
                ST_LOAD: begin
                    mcount_q  <= burst_size_c;
                    burst_cnt <= burst_size_c;
                end
                ST_READ: begin
                    if (rd_en_c) begin
                        burst_cnt <= burst_cnt - CNT_W'(1);
                        remaining <= remaining - LEN_BITS'(1);
                    end
                end
                default: begin
                end
            endcase
            wait_first <= (state == ST_LOAD);
            inflight   <= rd_en_c;
            busy_q     <= (next_state != ST_IDLE);
            done_q     <= (next_state == ST_DONE);
        end
    end

    concat_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (fifo_dout),
        .pop   (pop_c),
        .occ   (occ),
        .head  (m_data)
    );

    assign fifo_rd_en = rd_en_c;
    assign M_count    = mcount_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_concat_burst_reader.sv
// Directed bench for concat_burst_reader: behavioural FIFO model plus a scoreboard of words.
module tb_concat_burst_reader;

    localparam int unsigned WIDTH      = 128;
    localparam int unsigned ADDR_BITS  = 10;
    localparam int unsigned FIFO_DEPTH = 512;
    localparam int unsigned LEN_BITS   = 20;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [LEN_BITS-1:0]  total_words;
    logic [ADDR_BITS:0]   burst_len;
    logic [ADDR_BITS:0]   M_count;
    logic                 M_Ready = 1'b0;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [WIDTH-1:0]     fifo_dout = '0;
    logic                 m_valid;
    logic [WIDTH-1:0]     m_data;
    logic                 m_ready;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    concat_burst_reader #(
        .WIDTH      (WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_BITS   (LEN_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .total_words (total_words),
        .burst_len   (burst_len),
        .M_count     (M_count),
        .M_Ready     (M_Ready),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [WIDTH-1:0] word(input int r, input int i);
        return {32'(r), 32'(i), 32'(i * 7 + r * 13), ~32'(i)};
    endfunction

    // FIFO model: words of the current run are produced on demand; M_Ready lags one cycle.
    int run_id     = 0;
    int fifo_words = 0;
    int seen_run   = 0;
    int pop_idx    = 0;
    bit force_mrdy = 1'b0;

    always @(posedge clk) begin
        if (seen_run != run_id) begin
            seen_run <= run_id;
            pop_idx  <= 0;
        end else if (fifo_rd_en) begin
            fifo_dout <= word(run_id, pop_idx);
            pop_idx   <= pop_idx + 1;
        end
        M_Ready <= force_mrdy || ((fifo_words - pop_idx) >= int'(M_count));
    end

    assign fifo_empty = (pop_idx >= fifo_words);

    logic [WIDTH-1:0] expq[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, rd_cnt = 0, acc_cnt = 0, done_cnt = 0, last_acc_cyc = 0, outst = 0;
    int cur_total = 0, cur_blen = 1, rd_in_run = 0;
    bit prev_hold = 1'b0, last_rd = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_mc(input int idx);
        int rem;
        rem = cur_total - (idx / cur_blen) * cur_blen;
        return (cur_blen < rem) ? cur_blen : rem;
    endfunction

    // One clock: check outputs at the falling edge, return just after the next rising edge.
    task automatic tick();
        logic [WIDTH-1:0] e;
        @(negedge clk);
        cyc++;
        last_rd = 1'b0;
        if (rst_n) begin
            if (fifo_rd_en) begin
                chk("m_count_at_rd", WIDTH'(M_count), WIDTH'(exp_mc(rd_in_run)));
                rd_in_run++;
                rd_cnt++;
                outst++;
                last_rd = 1'b1;
            end
            if (prev_hold) begin
                chk("hold_valid", WIDTH'(m_valid), WIDTH'(1));
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("data", m_data, e);
                end else begin
                    chk("extra_word", WIDTH'(1), WIDTH'(0));
                end
                acc_cnt++;
                outst--;
                last_acc_cyc = cyc;
            end
            chk("credit", WIDTH'(outst <= 2), WIDTH'(1));
            if (done) begin
                done_cnt++;
                chk("done_busy", WIDTH'(busy), WIDTH'(1));
                if (cur_total != 0) chk("done_latency", WIDTH'(cyc), WIDTH'(last_acc_cyc + 1));
            end
            prev_hold = m_valid & !m_ready;
            prev_data = m_data;
        end else begin
            prev_hold = 1'b0;
            outst = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp_blen(input int bl);
        if (bl == 0) return 1;
        if (bl > int'(FIFO_DEPTH)) return int'(FIFO_DEPTH);
        return bl;
    endfunction

    task automatic arm_run(input int total, input int bl);
        run_id++;
        fifo_words = total;
        for (int i = 0; i < total; i++) expq.push_back(word(run_id, i));
        cur_total = total;
        cur_blen  = clamp_blen(bl);
        rd_in_run = 0;
        tick();
        start       = 1'b1;
        total_words = LEN_BITS'(total);
        burst_len   = (ADDR_BITS + 1)'(bl);
        tick();
        start = 1'b0;
    endtask

    task automatic run_xfer(input int total, input int bl, input bit stall, input bit chk_first, input bit poke);
        int rd0, acc0, d0, n, first_rd, run, max_run, hold;
        bit stalled;
        rd0 = rd_cnt; acc0 = acc_cnt; d0 = done_cnt;
        n = 0; first_rd = -1; run = 0; max_run = 0; hold = 0; stalled = 1'b0;
        arm_run(total, bl);
        while (done_cnt == d0 && n < 4000) begin
            tick();
            n++;
            if (start) start = 1'b0;
            if (last_rd) begin
                if (first_rd < 0) first_rd = n;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (stall && !stalled && (acc_cnt - acc0) >= 3) begin
                m_ready = 1'b0;
                hold    = 5;
                stalled = 1'b1;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) m_ready = 1'b1;
            end
            if (poke && n == 6) begin
                chk("poke_busy", WIDTH'(busy), WIDTH'(1));
                start       = 1'b1;
                total_words = LEN_BITS'(99);
                burst_len   = (ADDR_BITS + 1)'(3);
            end
        end
        chk("done_seen", WIDTH'(done_cnt > d0), WIDTH'(1));
        if (total == 0) chk("done_next_cycle", WIDTH'(n), WIDTH'(1));
        if (chk_first) chk("first_rd_cycle", WIDTH'(first_rd), WIDTH'(4));
        if (!stall && total > 0)
            chk("burst_run", WIDTH'(max_run), WIDTH'((cur_blen < total) ? cur_blen : total));
        tick();
        tick();
        chk("rd_count", WIDTH'(rd_cnt - rd0), WIDTH'(total));
        chk("acc_count", WIDTH'(acc_cnt - acc0), WIDTH'(total));
        chk("done_once", WIDTH'(done_cnt - d0), WIDTH'(1));
        chk("sb_empty", WIDTH'(expq.size()), WIDTH'(0));
        chk("busy_after", WIDTH'(busy), WIDTH'(0));
    endtask

    initial begin
        int rd0, n;
        rst_n = 1'b0; start = 1'b0; total_words = '0; burst_len = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_count", WIDTH'(M_count), WIDTH'(0));
        chk("rst_rd_en", WIDTH'(fifo_rd_en), WIDTH'(0));
        chk("rst_m_valid", WIDTH'(m_valid), WIDTH'(0));
        chk("rst_m_data", m_data, WIDTH'(0));
        chk("rst_busy", WIDTH'(busy), WIDTH'(0));
        chk("rst_done", WIDTH'(done), WIDTH'(0));
        rst_n = 1'b1;
        tick();

        run_xfer(0, 4, 1'b0, 1'b0, 1'b0);
        chk("zero_m_count", WIDTH'(M_count), WIDTH'(0));
        run_xfer(8, 4, 1'b0, 1'b1, 1'b0);
        run_xfer(10, 4, 1'b0, 1'b0, 1'b0);
        run_xfer(12, 6, 1'b1, 1'b0, 1'b0);
        force_mrdy = 1'b1;
        run_xfer(8, 3, 1'b0, 1'b1, 1'b0);
        force_mrdy = 1'b0;
        run_xfer(2, 0, 1'b0, 1'b0, 1'b0);
        run_xfer(600, 700, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a burst, then a clean run.
        rd0 = rd_cnt;
        arm_run(16, 8);
        n = 0;
        while ((rd_cnt - rd0) < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_reset_reads", WIDTH'((rd_cnt - rd0) >= 3), WIDTH'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", WIDTH'(fifo_rd_en), WIDTH'(0));
        chk("mid_rst_m_valid", WIDTH'(m_valid), WIDTH'(0));
        chk("mid_rst_m_data", m_data, WIDTH'(0));
        chk("mid_rst_m_count", WIDTH'(M_count), WIDTH'(0));
        chk("mid_rst_busy", WIDTH'(busy), WIDTH'(0));
        chk("mid_rst_done", WIDTH'(done), WIDTH'(0));
        expq.delete();
        run_id++;
        fifo_words = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_xfer(8, 4, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
